system_0_sysid_regs: RTL



---
 rtl/system_0_sysid_pkg.sv | 29 ++
 rtl/system_0_sysid_regs_if.sv | 24 ++
 rtl/system_0_sysid_uptime.sv | 43 ++++
 rtl/system_0_sysid_regs.sv | 98 +++++++++
 4 files changed

// File: rtl/system_0_sysid_pkg.sv
// Register map, CTRL bit positions and CAPS layout of the system_0 sysid block.
// The driver-header generator reads this package as well, so offsets live only here.
package system_0_sysid_pkg;

    localparam int OFF_ID        = 0;
    localparam int OFF_TIMESTAMP = 1;
    localparam int OFF_UPTIME_LO = 2;
    localparam int OFF_UPTIME_HI = 3;
    localparam int OFF_CTRL      = 4;
    localparam int OFF_CAPS      = 5;
    localparam int OFF_SCRATCH0  = 8;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

    localparam int CAPS_NS_LSB = 0;
    localparam int CAPS_NS_W   = 8;
    localparam int CAPS_PS_LSB = 8;
    localparam int CAPS_PS_W   = 16;

    function automatic logic [31:0] caps_word(input int prescale, input int num_scratch);
        logic [31:0] w;
        w = '0;
        w[CAPS_PS_LSB +: CAPS_PS_W] = prescale[15:0];
        w[CAPS_NS_LSB +: CAPS_NS_W] = num_scratch[7:0];
        return w;
    endfunction

endpackage

// File: rtl/system_0_sysid_regs_if.sv
// Avalon-MM slave bundle for the sysid block plus its uptime tick output.
interface system_0_sysid_regs_if #(
    parameter int ADDR_W = 4
) ();
    logic              chipselect;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic [31:0]       readdata;
    logic              readdatavalid;
    logic              tick;

    modport master (
        output chipselect, address, read, write, writedata, byteenable,
        input  readdata, readdatavalid, tick
    );

    modport slave (
        input  chipselect, address, read, write, writedata, byteenable,
        output readdata, readdatavalid, tick
    );
endinterface

// File: rtl/system_0_sysid_uptime.sv
// Prescaled free-running 64-bit uptime counter with enable, synchronous clear and tick pulse.
// tick is registered: it is high in the cycle in which the incremented uptime is visible.
module system_0_sysid_uptime #(
    parameter int PRESCALE = 50
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic        clr,
    output logic [63:0] uptime,
    output logic        tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre;
    logic          wrap;

    assign wrap = en && (pre == LAST);

    // Clear takes priority over a coincident wrap so software sees a clean zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre    <= '0;
            uptime <= '0;
            tick   <= 1'b0;
        end else if (clr) begin
            pre    <= '0;
            uptime <= '0;
            tick   <= 1'b0;
        end else begin
            tick <= wrap;
            if (wrap) begin
                pre    <= '0;
                uptime <= uptime + 64'd1;
            end else if (en) begin
                pre <= pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/system_0_sysid_regs.sv
// System-ID / housekeeping Avalon-MM slave: ID, timestamp, uptime, CTRL, CAPS, scratch words.
// Reads complete with fixed latency 1 via readdatavalid; no waitrequest, read wins over write.
module system_0_sysid_regs
    import system_0_sysid_pkg::*;
#(
    parameter logic [31:0] SYSID_ID    = 32'h6688_1AD9,
    parameter logic [31:0] TIMESTAMP   = 32'h0,
    parameter int          NUM_SCRATCH = 4,
    parameter int          PRESCALE    = 50,
    parameter int          ADDR_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    system_0_sysid_regs_if.slave  bus
);

    localparam int SW = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;

    logic [ADDR_W-1:0] addr;
    logic              rd_acc;
    logic              wr_acc;
    logic              in_scratch;
    logic [SW-1:0]     sidx;
    logic [31:0]       scratch [NUM_SCRATCH];
    logic [31:0]       hi_shadow;
    logic [31:0]       rdata;
    logic              en;
    logic              clr;
    logic              ctrl_wr;
    logic [63:0]       uptime;

    assign addr       = bus.address;
    assign rd_acc     = bus.chipselect && bus.read;
    assign wr_acc     = bus.chipselect && bus.write && !bus.read;
    assign in_scratch = (addr >= ADDR_W'(OFF_SCRATCH0)) &&
                        (addr <  ADDR_W'(OFF_SCRATCH0 + NUM_SCRATCH));
    assign sidx       = SW'(addr - ADDR_W'(OFF_SCRATCH0));
    assign ctrl_wr    = wr_acc && (addr == ADDR_W'(OFF_CTRL)) && bus.byteenable[0];
    assign clr        = ctrl_wr && bus.writedata[CTRL_CLR];

    system_0_sysid_uptime #(.PRESCALE(PRESCALE)) u_uptime (
        .clock  (clock),
        .reset  (reset),
        .en     (en),
        .clr    (clr),
        .uptime (uptime),
        .tick   (bus.tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en <= 1'b1;
        end else if (ctrl_wr) begin
            en <= bus.writedata[CTRL_EN];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
        end else if (wr_acc && in_scratch) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.byteenable[b]) scratch[sidx][8*b +: 8] <= bus.writedata[8*b +: 8];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (in_scratch) begin
            rdata = scratch[sidx];
        end else begin
            case (addr)
                ADDR_W'(OFF_ID):        rdata = SYSID_ID;
                ADDR_W'(OFF_TIMESTAMP): rdata = TIMESTAMP;
                ADDR_W'(OFF_UPTIME_LO): rdata = uptime[31:0];
                ADDR_W'(OFF_UPTIME_HI): rdata = hi_shadow;
                ADDR_W'(OFF_CTRL):      rdata[CTRL_EN] = en;
                ADDR_W'(OFF_CAPS):      rdata = caps_word(PRESCALE, NUM_SCRATCH);
                default:                rdata = '0;
            endcase
        end
    end

    // The high half is snapshotted by the low-half read so a 64-bit value is coherent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
            hi_shadow         <= '0;
        end else begin
            bus.readdatavalid <= rd_acc;
            if (rd_acc) bus.readdata <= rdata;
            if (rd_acc && addr == ADDR_W'(OFF_UPTIME_LO)) hi_shadow <= uptime[63:32];
        end
    end

endmodule
